// File: rtl/pi_nibble_ctrl.sv
// pi_nibble_ctrl: Raspberry Pi side sequencer for the TI/RPi register exchange.
// Synchronizes the Pi nibble strobes and moves one byte per nibrst-framed transaction.
module pi_nibble_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r_clk_in,
    input  logic       r_nibrst_in,
    input  logic [3:0] r_nib_i,
    output logic [3:0] r_nib_o,
    output logic       r_nib_oe,
    input  logic [7:0] td_q,
    input  logic [7:0] tc_q,
    output logic [7:0] rd_q,
    output logic [7:0] rc_q,
    output logic       rd_we,
    output logic       rc_we,
    output logic       busy,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        WR_LO,
        RD_TURN,
        RD_HI,
        RD_LO,
        DONE,
        IGNORE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0]      clk_sync;
    logic [SYNC_STAGES-1:0]      nibrst_sync;
    logic [SYNC_STAGES-1:0][3:0] nib_sync;

    logic       clk_prev;
    logic       clk_s;
    logic       nibrst_s;
    logic [3:0] nib_s;
    logic       edge_det;

    logic       sel;
    logic [3:0] hold;
    logic [7:0] shadow;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign nibrst_s = nibrst_sync[SYNC_STAGES-1];
    assign nib_s    = nib_sync[SYNC_STAGES-1];
    assign edge_det = clk_s & ~clk_prev;

    // Equal-depth chains keep the nibble aligned with its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync    <= '0;
            nibrst_sync <= '0;
            nib_sync    <= '0;
            clk_prev    <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], r_clk_in};
            nibrst_sync <= {nibrst_sync[SYNC_STAGES-2:0], r_nibrst_in};
            nib_sync    <= {nib_sync[SYNC_STAGES-2:0], r_nib_i};
            clk_prev    <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // nibrst has priority over any edge in the same cycle.
    always_comb begin
        state_nxt = state;
        if (nibrst_s) begin
            state_nxt = IDLE;
        end else if (edge_det) begin
            case (state)
                IDLE: begin
                    case (nib_s)
                        4'h0, 4'h1: state_nxt = RD_TURN;
                        4'h2, 4'h3: state_nxt = WR_HI;
                        default:    state_nxt = IGNORE;
                    endcase
                end
                WR_HI:   state_nxt = WR_LO;
                WR_LO:   state_nxt = DONE;
                RD_TURN: state_nxt = RD_HI;
                RD_HI:   state_nxt = RD_LO;
                RD_LO:   state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        r_nib_oe = 1'b0;
        r_nib_o  = 4'h0;
        case (state)
            RD_HI: begin
                r_nib_oe = 1'b1;
                r_nib_o  = shadow[7:4];
            end
            RD_LO: begin
                r_nib_oe = 1'b1;
                r_nib_o  = shadow[3:0];
            end
            default: begin
                r_nib_oe = 1'b0;
                r_nib_o  = 4'h0;
            end
        endcase
    end

    // The read byte is frozen at command time so TI updates mid-read cannot tear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= 1'b0;
            hold    <= 4'h0;
            shadow  <= 8'h00;
            rd_q    <= 8'h00;
            rc_q    <= 8'h00;
            rd_we   <= 1'b0;
            rc_we   <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            rd_we <= 1'b0;
            rc_we <= 1'b0;
            if (nibrst_s) begin
                hold    <= 4'h0;
                cmd_err <= 1'b0;
            end else if (edge_det) begin
                case (state)
                    IDLE: begin
                        sel <= nib_s[0];
                        if (nib_s[3:1] == 3'b000) begin
                            shadow <= nib_s[0] ? tc_q : td_q;
                        end
                        if (nib_s[3:2] != 2'b00) begin
                            cmd_err <= 1'b1;
                        end
                    end
                    WR_HI: begin
                        hold <= nib_s;
                    end
                    WR_LO: begin
                        if (sel) begin
                            rc_q  <= {hold, nib_s};
                            rc_we <= 1'b1;
                        end else begin
                            rd_q  <= {hold, nib_s};
                            rd_we <= 1'b1;
                        end
                    end
                    default: begin
                        hold <= hold;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pi_nibble_ctrl.sv
// tb_pi_nibble_ctrl: drives Pi-side nibble transactions against a transaction-level model.
module tb_pi_nibble_ctrl;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r_clk_in = 1'b0;
    logic       r_nibrst_in = 1'b0;
    logic [3:0] r_nib_i = 4'h0;
    logic [3:0] r_nib_o;
    logic       r_nib_oe;
    logic [7:0] td_q = 8'h00;
    logic [7:0] tc_q = 8'h00;
    logic [7:0] rd_q;
    logic [7:0] rc_q;
    logic       rd_we;
    logic       rc_we;
    logic       busy;
    logic       cmd_err;

    int checks = 0;
    int failures = 0;
    int rd_we_count = 0;
    int rc_we_count = 0;
    bit chk_en = 1'b0;

    int         m_edges = 0;
    logic [3:0] m_cmd = 4'h0;
    logic [3:0] m_hi = 4'h0;
    logic [7:0] m_shadow = 8'h00;
    logic [7:0] exp_rd_q = 8'h00;
    logic [7:0] exp_rc_q = 8'h00;
    logic       exp_rd_we = 1'b0;
    logic       exp_rc_we = 1'b0;

    pi_nibble_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .r_clk_in(r_clk_in),
        .r_nibrst_in(r_nibrst_in),
        .r_nib_i(r_nib_i),
        .r_nib_o(r_nib_o),
        .r_nib_oe(r_nib_oe),
        .td_q(td_q),
        .tc_q(tc_q),
        .rd_q(rd_q),
        .rc_q(rc_q),
        .rd_we(rd_we),
        .rc_we(rc_we),
        .busy(busy),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected outputs follow from the command and how many edges the transaction has seen.
    function automatic logic exp_oe();
        return (m_cmd <= 4'h1) && (m_edges == 2 || m_edges == 3);
    endfunction

    function automatic logic [3:0] exp_nib();
        return (m_edges == 2) ? m_shadow[7:4] : m_shadow[3:0];
    endfunction

    function automatic logic exp_busy();
        return m_edges > 0;
    endfunction

    function automatic logic exp_err();
        return (m_edges > 0) && (m_cmd > 4'h3);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] nib);
        if (m_edges == 0) begin
            m_cmd = nib;
            if (nib == 4'h0) m_shadow = td_q;
            else if (nib == 4'h1) m_shadow = tc_q;
        end else if (m_cmd == 4'h2 || m_cmd == 4'h3) begin
            if (m_edges == 1) begin
                m_hi = nib;
            end else if (m_edges == 2) begin
                if (m_cmd == 4'h2) begin
                    exp_rd_q  = {m_hi, nib};
                    exp_rd_we = 1'b1;
                end else begin
                    exp_rc_q  = {m_hi, nib};
                    exp_rc_we = 1'b1;
                end
            end
        end
        if (m_edges < 10) m_edges++;
    endtask

    // One Pi nibble-clock pulse carrying nib; the model takes effect when the DUT should.
    task automatic applyStimulus(input logic [3:0] nib);
        @(negedge clk);
        r_nib_i = nib;
        @(negedge clk);
        r_clk_in = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1 model_edge(nib);
        @(posedge clk);
        #1;
        exp_rd_we = 1'b0;
        exp_rc_we = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        r_clk_in = 1'b0;
        repeat (SYNC + 2 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic pulse_nibrst(input bit with_edge);
        @(negedge clk);
        r_nibrst_in = 1'b1;
        if (with_edge) r_clk_in = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        m_edges = 0;
        m_cmd   = 4'h0;
        m_hi    = 4'h0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        if (with_edge) begin
            @(negedge clk);
            r_clk_in = 1'b0;
            repeat (SYNC + 2) @(negedge clk);
        end
        @(negedge clk);
        r_nibrst_in = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("rd_q", rd_q, exp_rd_q);
            checkOutput("rc_q", rc_q, exp_rc_q);
            checkOutput("rd_we", {7'b0, rd_we}, {7'b0, exp_rd_we});
            checkOutput("rc_we", {7'b0, rc_we}, {7'b0, exp_rc_we});
            checkOutput("r_nib_oe", {7'b0, r_nib_oe}, {7'b0, exp_oe()});
            checkOutput("busy", {7'b0, busy}, {7'b0, exp_busy()});
            checkOutput("cmd_err", {7'b0, cmd_err}, {7'b0, exp_err()});
            if (exp_oe()) checkOutput("r_nib_o", {4'h0, r_nib_o}, {4'h0, exp_nib()});
            if (rd_we) rd_we_count++;
            if (rc_we) rc_we_count++;
        end
    end

    initial begin
        int rd_before;
        int rc_before;
        logic [3:0] cmd;
        repeat (3) @(negedge clk);
        checkOutput("reset_rd_q", rd_q, 8'h00);
        checkOutput("reset_rc_q", rc_q, 8'h00);
        checkOutput("reset_oe", {7'b0, r_nib_oe}, 8'h00);
        checkOutput("reset_nib_o", {4'h0, r_nib_o}, 8'h00);
        checkOutput("reset_busy", {7'b0, busy}, 8'h00);
        checkOutput("reset_cmd_err", {7'b0, cmd_err}, 8'h00);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_busy", {7'b0, busy}, 8'h00);

        $display("[TB] write RD 0xA5");
        rd_before = rd_we_count;
        pulse_nibrst(1'b0);
        applyStimulus(4'h2);
        applyStimulus(4'hA);
        applyStimulus(4'h5);
        checkOutput("wr_rd_value", rd_q, 8'hA5);
        checkOutput("wr_rd_pulses", 8'(rd_we_count - rd_before), 8'h01);
        checkOutput("wr_rd_rc_untouched", rc_q, 8'h00);
        checkOutput("done_busy", {7'b0, busy}, 8'h01);

        $display("[TB] write RC 0x6B");
        rc_before = rc_we_count;
        pulse_nibrst(1'b0);
        applyStimulus(4'h3);
        applyStimulus(4'h6);
        applyStimulus(4'hB);
        checkOutput("wr_rc_value", rc_q, 8'h6B);
        checkOutput("wr_rc_pulses", 8'(rc_we_count - rc_before), 8'h01);

        $display("[TB] read TC then TD");
        tc_q = 8'h55;
        td_q = 8'hA5;
        pulse_nibrst(1'b0);
        applyStimulus(4'h1);
        checkOutput("rd_tc_turn_oe", {7'b0, r_nib_oe}, 8'h00);
        applyStimulus(4'h0);
        checkOutput("rd_tc_hi_oe", {7'b0, r_nib_oe}, 8'h01);
        checkOutput("rd_tc_hi_nib", {4'h0, r_nib_o}, 8'h05);
        applyStimulus(4'h0);
        checkOutput("rd_tc_lo_nib", {4'h0, r_nib_o}, 8'h05);
        applyStimulus(4'h0);
        checkOutput("rd_tc_end_oe", {7'b0, r_nib_oe}, 8'h00);
        pulse_nibrst(1'b0);
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        checkOutput("rd_td_hi_nib", {4'h0, r_nib_o}, 8'h0A);
        applyStimulus(4'h0);
        checkOutput("rd_td_lo_nib", {4'h0, r_nib_o}, 8'h05);
        applyStimulus(4'h0);
        checkOutput("rd_td_end_oe", {7'b0, r_nib_oe}, 8'h00);

        $display("[TB] aborted write then full write");
        rd_before = rd_we_count;
        pulse_nibrst(1'b0);
        applyStimulus(4'h2);
        applyStimulus(4'hA);
        pulse_nibrst(1'b0);
        checkOutput("abort_rd_kept", rd_q, 8'hA5);
        checkOutput("abort_no_pulse", 8'(rd_we_count - rd_before), 8'h00);
        applyStimulus(4'h2);
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        checkOutput("rewrite_rd", rd_q, 8'h12);

        $display("[TB] invalid command");
        pulse_nibrst(1'b0);
        applyStimulus(4'h7);
        checkOutput("bad_cmd_err", {7'b0, cmd_err}, 8'h01);
        applyStimulus(4'h3);
        applyStimulus(4'h9);
        checkOutput("bad_rd_kept", rd_q, 8'h12);
        checkOutput("bad_rc_kept", rc_q, 8'h6B);
        checkOutput("bad_oe", {7'b0, r_nib_oe}, 8'h00);
        pulse_nibrst(1'b0);
        checkOutput("bad_err_cleared", {7'b0, cmd_err}, 8'h00);

        $display("[TB] snapshot during read");
        td_q = 8'hA5;
        pulse_nibrst(1'b0);
        applyStimulus(4'h0);
        td_q = 8'h3C;
        applyStimulus(4'h0);
        checkOutput("snap_hi", {4'h0, r_nib_o}, 8'h0A);
        applyStimulus(4'h0);
        checkOutput("snap_lo", {4'h0, r_nib_o}, 8'h05);

        $display("[TB] nibrst coincident with an edge");
        pulse_nibrst(1'b1);
        checkOutput("coincident_busy", {7'b0, busy}, 8'h00);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            td_q = 8'($urandom);
            tc_q = 8'($urandom);
            pulse_nibrst($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) < 8) cmd = 4'($urandom_range(0, 3));
            else cmd = 4'($urandom_range(4, 15));
            applyStimulus(cmd);
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    td_q = 8'($urandom);
                    tc_q = 8'($urandom);
                end
                applyStimulus(4'($urandom));
            end
        end

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
